e203_exu_flush_arb: RTL and testbench
=====================================

E203_EXU_FLUSH_ARB -- requirements
Module: e203_exu_flush_arb

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning number of flush sources (legal 2..8); source 0 has highest priority.
REQ-002 SHALL have parameter PC_SIZE, default 32, meaning flush adder operand width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning flush counter width.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 src_flush_req  input  NCH  per-source flush request.
REQ-007 src_flush_ack  output  NCH  per-source acknowledge.
REQ-008 src_add_op1  input  NCH*PC_SIZE  per-source operand 1; source i occupies bits [i*PC_SIZE +: PC_SIZE].
REQ-009 src_add_op2  input  NCH*PC_SIZE  per-source operand 2; same packing as src_add_op1.
REQ-010 pipe_flush_req  output  1  flush request to IFU.
REQ-011 pipe_flush_ack  input  1  IFU acknowledge.
REQ-012 pipe_flush_add_op1  output  PC_SIZE  granted operand 1.
REQ-013 pipe_flush_add_op2  output  PC_SIZE  granted operand 2.
REQ-014 pipe_flush_src  output  clog2(NCH)  index of granted source.
REQ-015 cmt_valid  input  1  a commit is presented this cycle.
REQ-016 nonflush_cmt_ena  output  1  commit not accompanied by flush.
REQ-017 flush_pulse  output  1  flush handshake completes this cycle.
REQ-018 flush_cnt  output  CNT_W  completed-flush count.

Function
REQ-019 SHALL implement two states: IDLE (no grant) and LOCK (grant index held in register).
REQ-020 In IDLE, arbitration SHALL select the lowest-index asserted src_flush_req.
REQ-021 A grant SHALL NOT be preempted in LOCK; a higher-priority request arriving meanwhile waits for the next IDLE arbitration.
REQ-022 src_flush_ack[i] SHALL equal pipe_flush_ack AND pipe_flush_req AND (granted index == i); all other bits 0.
REQ-023 flush_pulse SHALL equal pipe_flush_req AND pipe_flush_ack.
REQ-024 On flush_pulse, state SHALL return to IDLE the next cycle; any remaining requests are arbitrated in that IDLE cycle.
REQ-025 If the locked source deasserts src_flush_req while in LOCK without ack, the FSM SHALL return to IDLE, with no pulse and no count.
REQ-026 nonflush_cmt_ena SHALL equal cmt_valid AND NOT pipe_flush_req.
REQ-027 flush_cnt SHALL increment by 1 on each flush_pulse and saturate at all-ones; no wrap.
REQ-028 When pipe_flush_req is 0, pipe_flush_add_op1/op2 and pipe_flush_src SHALL be 0.

Reset
REQ-029 While rst is high at a clock edge, the FSM SHALL enter IDLE, and the grant index, operand registers and flush_cnt SHALL become 0.
REQ-030 Outputs after reset: pipe_flush_req=0, src_flush_ack=0, flush_pulse=0, flush_cnt=0, pipe_flush_src=0, operands=0, nonflush_cmt_ena=cmt_valid.
REQ-031 Reset asserted mid-handshake SHALL abandon the flush; no pulse is generated and no count is taken in that cycle.

Configuration
REQ-032 The macro E203_FLUSH_ARB_REG_EN SHALL select the registered-output mode.
REQ-033 With E203_FLUSH_ARB_REG_EN undefined, the module SHALL operate in 0-cycle mode:
- pipe_flush_req is asserted combinationally in IDLE when any request is present.
- Operands are passed through from the selected source.
- If the flush is acked in the same cycle, the FSM stays in IDLE; otherwise it enters LOCK.
REQ-034 With E203_FLUSH_ARB_REG_EN defined, the module SHALL operate in 1-cycle mode:
- In IDLE, the arbiter latches the winner's index and operands, then enters LOCK.
- pipe_flush_req is asserted only in LOCK, and operands come from the registers.
- pipe_flush_ack is ignored in IDLE.

Verification
REQ-035 Config: off. Stimulus: src_flush_req=2'b01, op1=0x100, op2=0x4, pipe_flush_ack=1, same cycle. Required: pipe_flush_req=1, op1=0x100, op2=0x4, src_flush_ack=01, flush_pulse=1, flush_cnt=1 next cycle.
REQ-036 Stimulus: src_flush_req=2'b11, ack held 0 for 3 cycles, then 1. Required: pipe_flush_src=0 throughout; src_flush_ack=01 on the ack cycle; source 1 is granted in the following IDLE cycle.
REQ-037 Stimulus: source 1 is locked, source 0 asserts in the next cycle, ack is 0. Required: pipe_flush_src stays 1 until ack; then source 0 is served.
REQ-038 Config: on. Stimulus: src_flush_req=2'b10, op1=0x200, pipe_flush_ack=1 constantly. Required: pipe_flush_req=0 in cycle 0; in cycle 1, req=1, op1=0x200, src=1, flush_pulse=1.
REQ-039 Stimulus: CNT_W=4; 17 completed flushes. Required: flush_cnt reads 15 after the 15th pulse and stays 15.
REQ-040 Stimulus: rst=1 during LOCK with ack=1 in the same cycle, and cmt_valid=1. Required: flush_pulse is not counted; flush_cnt=0; pipe_flush_req=0 next cycle; nonflush_cmt_ena=1.

Source files
------------

// File: rtl/e203_exu_flush_arb_if.sv
// Flush handshake bundle between the flush sources, the arbiter and the IFU.
// The master modport is the arbiter side; the slave modport is the source/IFU side.
interface e203_exu_flush_arb_if #(
    parameter int NCH     = 2,
    parameter int PC_SIZE = 32
);
    localparam int SRC_W = $clog2(NCH);

    logic [NCH-1:0]         src_flush_req;
    logic [NCH-1:0]         src_flush_ack;
    logic [NCH*PC_SIZE-1:0] src_add_op1;
    logic [NCH*PC_SIZE-1:0] src_add_op2;
    logic                   pipe_flush_req;
    logic                   pipe_flush_ack;
    logic [PC_SIZE-1:0]     pipe_flush_add_op1;
    logic [PC_SIZE-1:0]     pipe_flush_add_op2;
    logic [SRC_W-1:0]       pipe_flush_src;

    modport master (
        input  src_flush_req, src_add_op1, src_add_op2, pipe_flush_ack,
        output src_flush_ack, pipe_flush_req, pipe_flush_add_op1,
               pipe_flush_add_op2, pipe_flush_src
    );

    modport slave (
        output src_flush_req, src_add_op1, src_add_op2, pipe_flush_ack,
        input  src_flush_ack, pipe_flush_req, pipe_flush_add_op1,
               pipe_flush_add_op2, pipe_flush_src
    );
endinterface

// File: rtl/e203_exu_flush_arb.sv
// Fixed-priority flush arbiter (source 0 highest) with non-preemptive grant lock and flush counter.
// Define E203_FLUSH_ARB_REG_EN for the registered (1-cycle) output mode; default is 0-cycle pass-through.
module e203_exu_flush_arb #(
    parameter int NCH     = 2,
    parameter int PC_SIZE = 32,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    e203_exu_flush_arb_if.master     bus,
    input  logic                     cmt_valid,
    output logic                     nonflush_cmt_ena,
    output logic                     flush_pulse,
    output logic [CNT_W-1:0]         flush_cnt
);
    localparam int SRC_W = $clog2(NCH);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q;

    logic               arb_any;
    logic [SRC_W-1:0]   arb_idx;
    logic [SRC_W-1:0]   sel_idx;
    logic               sel_req;
    logic [PC_SIZE-1:0] sel_op1, sel_op2;
    logic               req_int;
    logic [PC_SIZE-1:0] op1_int, op2_int;

    // Descending scan so the lowest asserted index wins.
    always_comb begin
        arb_any = 1'b0;
        arb_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (bus.src_flush_req[i]) begin
                arb_any = 1'b1;
                arb_idx = SRC_W'(i);
            end
        end
    end

    // In IDLE the fresh winner is looked at; in LOCK only the held grant matters.
    assign sel_idx = (state_q == IDLE) ? arb_idx : grant_q;

    always_comb begin
        sel_req = 1'b0;
        sel_op1 = '0;
        sel_op2 = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_idx == SRC_W'(i)) begin
                sel_req = bus.src_flush_req[i];
                sel_op1 = bus.src_add_op1[i*PC_SIZE +: PC_SIZE];
                sel_op2 = bus.src_add_op2[i*PC_SIZE +: PC_SIZE];
            end
        end
    end

`ifdef E203_FLUSH_ARB_REG_EN
    logic [PC_SIZE-1:0] op1_q, op1_d, op2_q, op2_d;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        req_int = 1'b0;
        op1_int = op1_q;
        op2_int = op2_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = LOCK;
                    grant_d = arb_idx;
                    op1_d   = sel_op1;
                    op2_d   = sel_op2;
                end
            end
            LOCK: begin
                req_int = sel_req;
                if (!sel_req || bus.pipe_flush_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op1_q <= '0;
            op2_q <= '0;
        end else begin
            op1_q <= op1_d;
            op2_q <= op2_d;
        end
    end
`else
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        req_int = 1'b0;
        op1_int = sel_op1;
        op2_int = sel_op2;
        case (state_q)
            IDLE: begin
                req_int = arb_any;
                if (arb_any && !bus.pipe_flush_ack) begin
                    state_d = LOCK;
                    grant_d = arb_idx;
                end
            end
            LOCK: begin
                req_int = sel_req;
                if (!sel_req || bus.pipe_flush_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Reset has priority, so a handshake in a reset cycle is never counted.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (flush_pulse && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    always_comb begin
        bus.src_flush_ack = '0;
        for (int i = 0; i < NCH; i++)
            bus.src_flush_ack[i] = bus.pipe_flush_ack & req_int & (sel_idx == SRC_W'(i));
    end

    assign bus.pipe_flush_req     = req_int;
    assign bus.pipe_flush_add_op1 = req_int ? op1_int : '0;
    assign bus.pipe_flush_add_op2 = req_int ? op2_int : '0;
    assign bus.pipe_flush_src     = req_int ? sel_idx : '0;
    assign flush_pulse            = req_int & bus.pipe_flush_ack;
    assign nonflush_cmt_ena       = cmt_valid & ~req_int;
    assign flush_cnt              = cnt_q;

endmodule

// File: tb/tb_e203_exu_flush_arb.sv
// Directed bench for e203_exu_flush_arb (2 sources, 4-bit counter); checks follow the
// build's E203_FLUSH_ARB_REG_EN setting.
module tb_e203_exu_flush_arb;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmt_valid;
    logic       nonflush_cmt_ena;
    logic       flush_pulse;
    logic [3:0] flush_cnt;
    int         nVec = 0;
    int         nMiss = 0;

    e203_exu_flush_arb_if #(.NCH(2), .PC_SIZE(32)) bus ();

    e203_exu_flush_arb #(.NCH(2), .PC_SIZE(32), .CNT_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .cmt_valid        (cmt_valid),
        .nonflush_cmt_ena (nonflush_cmt_ena),
        .flush_pulse      (flush_pulse),
        .flush_cnt        (flush_cnt)
    );

    always #5 clk = ~clk;

    // Move one cycle on, landing 1 time unit past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive request/ack/commit inputs, then let the combinational outputs settle.
    task automatic applyStimulus(input logic [1:0] req, input logic ack, input logic cmt);
        bus.src_flush_req  = req;
        bus.pipe_flush_ack = ack;
        cmt_valid          = cmt;
        #1;
    endtask

    // One comparison: count it, and report a miscompare with observed/expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nVec++;
        assert (observed === expected)
        else begin
            nMiss++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Directed sequence; source 0 carries 0x100/0x4 and source 1 carries 0x200/0x8.
    initial begin
        bus.src_add_op1 = {32'h200, 32'h100};
        bus.src_add_op2 = {32'h8, 32'h4};
        rst = 1'b1;
        applyStimulus(2'b00, 1'b0, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b1);
        checkOutput("rst_pipe_req", 32'(bus.pipe_flush_req), 32'd0);
        checkOutput("rst_src_ack", 32'(bus.src_flush_ack), 32'd0);
        checkOutput("rst_pulse", 32'(flush_pulse), 32'd0);
        checkOutput("rst_cnt", 32'(flush_cnt), 32'd0);
        checkOutput("rst_src", 32'(bus.pipe_flush_src), 32'd0);
        checkOutput("rst_op1", bus.pipe_flush_add_op1, 32'd0);
        checkOutput("rst_op2", bus.pipe_flush_add_op2, 32'd0);
        checkOutput("rst_nonflush", 32'(nonflush_cmt_ena), 32'd1);
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("rst_nonflush_off", 32'(nonflush_cmt_ena), 32'd0);

`ifdef E203_FLUSH_ARB_REG_EN
        // Registered mode: ack held high, request only shows up once locked.
        applyStimulus(2'b10, 1'b1, 1'b1);
        checkOutput("reg_c0_req", 32'(bus.pipe_flush_req), 32'd0);
        checkOutput("reg_c0_pulse", 32'(flush_pulse), 32'd0);
        checkOutput("reg_c0_nonflush", 32'(nonflush_cmt_ena), 32'd1);
        tick();
        applyStimulus(2'b10, 1'b1, 1'b1);
        checkOutput("reg_c1_req", 32'(bus.pipe_flush_req), 32'd1);
        checkOutput("reg_c1_op1", bus.pipe_flush_add_op1, 32'h200);
        checkOutput("reg_c1_op2", bus.pipe_flush_add_op2, 32'h8);
        checkOutput("reg_c1_src", 32'(bus.pipe_flush_src), 32'd1);
        checkOutput("reg_c1_pulse", 32'(flush_pulse), 32'd1);
        checkOutput("reg_c1_ack", 32'(bus.src_flush_ack), 32'b10);
        tick();
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("reg_cnt1", 32'(flush_cnt), 32'd1);
        checkOutput("reg_idle_req", 32'(bus.pipe_flush_req), 32'd0);
`else
        // Same-cycle request and ack.
        applyStimulus(2'b01, 1'b1, 1'b1);
        checkOutput("t35_req", 32'(bus.pipe_flush_req), 32'd1);
        checkOutput("t35_op1", bus.pipe_flush_add_op1, 32'h100);
        checkOutput("t35_op2", bus.pipe_flush_add_op2, 32'h4);
        checkOutput("t35_ack", 32'(bus.src_flush_ack), 32'b01);
        checkOutput("t35_pulse", 32'(flush_pulse), 32'd1);
        checkOutput("t35_nonflush", 32'(nonflush_cmt_ena), 32'd0);
        tick();
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("t35_cnt", 32'(flush_cnt), 32'd1);
        checkOutput("t35_idle_op1", bus.pipe_flush_add_op1, 32'd0);
        tick();

        // Both request; source 0 held for three unacked cycles.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(2'b11, 1'b0, 1'b0);
            checkOutput("t36_wait_src", 32'(bus.pipe_flush_src), 32'd0);
            checkOutput("t36_wait_req", 32'(bus.pipe_flush_req), 32'd1);
            checkOutput("t36_wait_ack", 32'(bus.src_flush_ack), 32'd0);
            tick();
        end
        applyStimulus(2'b11, 1'b1, 1'b0);
        checkOutput("t36_ack_src", 32'(bus.pipe_flush_src), 32'd0);
        checkOutput("t36_ack", 32'(bus.src_flush_ack), 32'b01);
        checkOutput("t36_pulse", 32'(flush_pulse), 32'd1);
        tick();
        applyStimulus(2'b10, 1'b0, 1'b0);
        checkOutput("t36_next_src", 32'(bus.pipe_flush_src), 32'd1);
        checkOutput("t36_next_op1", bus.pipe_flush_add_op1, 32'h200);
        checkOutput("t36_cnt", 32'(flush_cnt), 32'd2);
        tick();

        // Source 1 locked; source 0 must not preempt it.
        for (int c = 0; c < 2; c++) begin
            applyStimulus(2'b11, 1'b0, 1'b0);
            checkOutput("t37_hold_src", 32'(bus.pipe_flush_src), 32'd1);
            checkOutput("t37_hold_op2", bus.pipe_flush_add_op2, 32'h8);
            tick();
        end
        applyStimulus(2'b11, 1'b1, 1'b0);
        checkOutput("t37_ack", 32'(bus.src_flush_ack), 32'b10);
        tick();
        applyStimulus(2'b01, 1'b0, 1'b0);
        checkOutput("t37_cnt", 32'(flush_cnt), 32'd3);
        checkOutput("t37_serve0", 32'(bus.pipe_flush_src), 32'd0);
        checkOutput("t37_serve0_op1", bus.pipe_flush_add_op1, 32'h100);
        tick();
        applyStimulus(2'b01, 1'b1, 1'b0);
        checkOutput("t37_pulse0", 32'(flush_pulse), 32'd1);
        tick();

        // Locked source withdraws; ack arriving then must not produce a pulse.
        applyStimulus(2'b10, 1'b0, 1'b0);
        checkOutput("t25_lock_src", 32'(bus.pipe_flush_src), 32'd1);
        tick();
        applyStimulus(2'b00, 1'b1, 1'b1);
        checkOutput("t25_req", 32'(bus.pipe_flush_req), 32'd0);
        checkOutput("t25_pulse", 32'(flush_pulse), 32'd0);
        checkOutput("t25_ack", 32'(bus.src_flush_ack), 32'd0);
        checkOutput("t25_nonflush", 32'(nonflush_cmt_ena), 32'd1);
        tick();
        applyStimulus(2'b01, 1'b0, 1'b0);
        checkOutput("t25_idle_req", 32'(bus.pipe_flush_req), 32'd1);
        checkOutput("t25_idle_src", 32'(bus.pipe_flush_src), 32'd0);
        checkOutput("t25_cnt", 32'(flush_cnt), 32'd4);
        tick();
        applyStimulus(2'b01, 1'b1, 1'b0);
        tick();

        // Flushes 6..17: counter climbs to 15 and stays there.
        for (int k = 6; k <= 17; k++) begin
            applyStimulus(2'b01, 1'b1, 1'b0);
            checkOutput("sat_pulse", 32'(flush_pulse), 32'd1);
            tick();
            checkOutput("sat_cnt", 32'(flush_cnt), (k > 15) ? 32'd15 : 32'(k));
        end

        // Reset during LOCK with ack high abandons the flush.
        applyStimulus(2'b01, 1'b0, 1'b1);
        checkOutput("t40_pre_nonflush", 32'(nonflush_cmt_ena), 32'd0);
        tick();
        rst = 1'b1;
        applyStimulus(2'b01, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b1);
        checkOutput("t40_cnt", 32'(flush_cnt), 32'd0);
        checkOutput("t40_req", 32'(bus.pipe_flush_req), 32'd0);
        checkOutput("t40_nonflush", 32'(nonflush_cmt_ena), 32'd1);
        applyStimulus(2'b10, 1'b0, 1'b0);
        checkOutput("t40_idle_src", 32'(bus.pipe_flush_src), 32'd1);
        checkOutput("t40_idle_req", 32'(bus.pipe_flush_req), 32'd1);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end
endmodule
